// File: rtl/sublime_pkg.sv
// rtl/sublime_pkg.sv - shared I2S framing and volume constants for the sublime audio path
package sublime_pkg;

  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int VOL_UNITY      = 256;

  localparam int BITCNT_W      = $clog2(I2S_FRAME_BITS);
  localparam int VOL_FRAC_BITS = $clog2(VOL_UNITY);

  typedef logic [BITCNT_W-1:0] bitcnt_t;

endpackage

// File: rtl/sublime_vol_scale.sv
// rtl/sublime_vol_scale.sv - two-stage sign-magnitude volume scaler with headroom shift
// Output reduction clamps when SUBLIME_I2S_SATURATE_EN is defined, otherwise wraps.
module sublime_vol_scale
  import sublime_pkg::*;
#(
  parameter int OUT_BITS = 16,
  parameter int SHIFT    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [31:0]         sample,
  input  logic [8:0]          vol,
  output logic [OUT_BITS-1:0] word,
  output logic                clip
);

  logic [31:0]        mag;
  logic [32:0]        mag_q;
  logic               neg_q;
  logic               valid_q;
  logic signed [33:0] scaled;

  // Magnitude of -2^31 is 2^31, which still fits the unsigned 32-bit operand.
  assign mag = sample[31] ? 32'(-sample) : sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q   <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        mag_q <= 33'(({9'b0, mag} * {32'b0, vol}) >> VOL_FRAC_BITS);
        neg_q <= sample[31];
      end
    end
  end

  // Dropping fraction bits on the magnitude truncates toward zero.
  assign scaled = neg_q ? -$signed({1'b0, mag_q}) : $signed({1'b0, mag_q});

`ifdef SUBLIME_I2S_SATURATE_EN
  localparam logic signed [33:0] MAX_V = (34'sd1 <<< (OUT_BITS - 1)) - 34'sd1;
  localparam logic signed [33:0] MIN_V = -(34'sd1 <<< (OUT_BITS - 1));

  logic signed [33:0] shifted;

  assign shifted = scaled >>> SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      clip <= 1'b0;
    end else begin
      clip <= 1'b0;
      if (valid_q) begin
        if (shifted > MAX_V) begin
          word <= MAX_V[OUT_BITS-1:0];
          clip <= 1'b1;
        end else if (shifted < MIN_V) begin
          word <= MIN_V[OUT_BITS-1:0];
          clip <= 1'b1;
        end else begin
          word <= shifted[OUT_BITS-1:0];
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
    end else if (valid_q) begin
      word <= OUT_BITS'(scaled >>> SHIFT);
    end
  end

  assign clip = 1'b0;
`endif

endmodule

// File: rtl/sublime_i2s_out.sv
// rtl/sublime_i2s_out.sv - I2S serializer with volume scaling of a held mixer sample
// Optional output saturation and clipped pulse: define SUBLIME_I2S_SATURATE_EN.
module sublime_i2s_out
  import sublime_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int SAMPLE_BITS    = 16,
  parameter int HEADROOM_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sample_in,
  input  logic [8:0]  master_vol,
  output logic        frame_start,
  output logic        clipped,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata
);

  logic [7:0]                 div;
  logic                       div_wrap;
  logic                       bclk_fall;
  bitcnt_t                    bitcnt;
  bitcnt_t                    next_cnt;
  logic [I2S_SLOT_BITS-1:0]   shreg;
  logic [31:0]                cap_sample;
  logic [8:0]                 cap_vol;
  logic [SAMPLE_BITS-1:0]     word;

  assign div_wrap  = (div == 8'(CLK_DIV - 1));
  assign bclk_fall = div_wrap && bclk;
  assign next_cnt  = bitcnt + 1'b1;
  assign sdata     = shreg[I2S_SLOT_BITS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      bitcnt      <= '1;
      shreg       <= '0;
      frame_start <= 1'b0;
      cap_sample  <= '0;
      cap_vol     <= '0;
    end else begin
      frame_start <= 1'b0;
      if (div_wrap) begin
        div  <= '0;
        bclk <= ~bclk;
      end else begin
        div <= div + 8'd1;
      end

      if (bclk_fall) begin
        bitcnt <= next_cnt;
        lrclk  <= next_cnt[BITCNT_W-1];
        if (next_cnt == '0) begin
          cap_sample  <= sample_in;
          cap_vol     <= master_vol;
          frame_start <= 1'b1;
        end
        // Loading one slot after the word-select edge gives the standard I2S MSB delay.
        if (next_cnt == bitcnt_t'(1) || next_cnt == bitcnt_t'(I2S_SLOT_BITS + 1)) begin
          shreg <= {word, {(I2S_SLOT_BITS - SAMPLE_BITS){1'b0}}};
        end else begin
          shreg <= {shreg[I2S_SLOT_BITS-2:0], 1'b0};
        end
      end
    end
  end

  sublime_vol_scale #(
    .OUT_BITS (SAMPLE_BITS),
    .SHIFT    (HEADROOM_SHIFT)
  ) u_vol_scale (
    .clk      (clk),
    .rst      (rst),
    .in_valid (frame_start),
    .sample   (cap_sample),
    .vol      (cap_vol),
    .word     (word),
    .clip     (clipped)
  );

endmodule

// File: tb/tb_sublime_i2s_out.sv
// tb/tb_sublime_i2s_out.sv - self-checking bench for sublime_i2s_out (default parameters)
module tb_sublime_i2s_out;

  localparam int CLK_DIV = 4;
  localparam int SB      = 16;
  localparam int HS      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sample_in;
  logic [8:0]  master_vol;
  logic        frame_start, clipped, bclk, lrclk, sdata;

  int total = 0, passed = 0, fails = 0, clip_cnt = 0;
  logic [63:0] got_bits, got_lr;

  always #5 clk = ~clk;

  sublime_i2s_out #(
    .CLK_DIV        (CLK_DIV),
    .SAMPLE_BITS    (SB),
    .HEADROOM_SHIFT (HS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .master_vol  (master_vol),
    .frame_start (frame_start),
    .clipped     (clipped),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (clipped === 1'b1) clip_cnt++;
  endtask

  // Expected word from the arithmetic definition: truncate toward zero, then floor-divide.
  function automatic logic [15:0] ref_word(input logic [31:0] s, input int v, output int clip);
    longint sv, mag, t, val, q;
    logic [63:0] qv;
    sv   = longint'($signed(s));
    mag  = (sv < 0) ? -sv : sv;
    t    = (mag * v) / 256;
    val  = (sv < 0) ? -t : t;
    q    = (val >= 0) ? val / 256 : -((-val + 255) / 256);
    clip = 0;
`ifdef SUBLIME_I2S_SATURATE_EN
    if (q > 32767) begin q = 32767; clip = 1; end
    if (q < -32768) begin q = -32768; clip = 1; end
`endif
    qv = q;
    return qv[15:0];
  endfunction

  function automatic logic [63:0] frame_bits(input logic [15:0] w);
    logic [63:0] f = '0;
    for (int i = 0; i < SB; i++) begin
      f[63 - (1 + i)]  = w[SB - 1 - i];
      f[63 - (33 + i)] = w[SB - 1 - i];
    end
    return f;
  endfunction

  task automatic wait_rise(output bit ok);
    logic prev;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      prev = bclk;
      tick();
      if (bclk && !prev) begin ok = 1'b1; break; end
    end
  endtask

  task automatic collect(input string tag, input int stop, input int chg_slot, input logic [31:0] chg_val);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (frame_start) begin ok = 1'b1; break; end
    end
    if (!ok) begin check({tag, " frame_start timeout"}, 64'(ok), 64'd1); return; end
    clip_cnt = 0;
    got_bits = '0;
    got_lr   = '0;
    for (int s = 0; s < stop; s++) begin
      wait_rise(ok);
      if (!ok) begin check({tag, " bclk timeout"}, 64'(ok), 64'd1); return; end
      got_bits[63 - s] = sdata;
      got_lr[63 - s]   = lrclk;
      if (s == chg_slot) sample_in = chg_val;
    end
  endtask

  task automatic frame(input string tag, input logic [31:0] s, input logic [8:0] v,
                       input logic [15:0] exp_word, input int exp_clip);
    sample_in  = s;
    master_vol = v;
    collect(tag, 64, -1, 32'd0);
    check({tag, " data"}, got_bits, frame_bits(exp_word));
    check({tag, " lrclk"}, got_lr, 64'h0000_0000_FFFF_FFFF);
    check({tag, " clipped"}, 64'(clip_cnt), 64'(exp_clip));
  endtask

  task automatic startup(input string tag);
    int r1 = -1, r2 = -1, f = -1;
    logic prev;
    rst = 1'b0;
    for (int n = 1; n <= 100 && r2 < 0; n++) begin
      prev = bclk;
      tick();
      if (bclk && !prev) begin
        if (r1 < 0) r1 = n;
        else r2 = n;
      end
      if (frame_start && f < 0) f = n;
    end
    check({tag, " first bclk rise"}, 64'(r1), 64'(CLK_DIV));
    check({tag, " first frame_start"}, 64'(f), 64'(2 * CLK_DIV));
    check({tag, " bclk period"}, 64'(r2 - r1), 64'(2 * CLK_DIV));
  endtask

  initial begin
    logic [31:0] s, a, b;
    logic [8:0]  v;
    logic [15:0] w;
    int          c, l1, l2, n;
    logic        prev;

    rst = 1'b1;
    sample_in = '0;
    master_vol = '0;
    repeat (3) tick();
    check("reset outputs", 64'({bclk, lrclk, sdata, frame_start, clipped}), 64'd0);
    startup("startup");

    l1 = -1; l2 = -1; n = 0;
    while (l2 < 0 && n < 1500) begin
      prev = lrclk;
      tick();
      n++;
      if (lrclk && !prev) begin
        if (l1 < 0) l1 = n;
        else l2 = n;
      end
    end
    check("lrclk period", 64'(l2 - l1), 64'(64 * 2 * CLK_DIV));

    frame("unity", 32'h0012_3400, 9'd256, 16'h1234, 0);
    frame("half_neg", 32'hFFFF_EC00, 9'd128, 16'hFFF6, 0);
`ifdef SUBLIME_I2S_SATURATE_EN
    frame("overflow", 32'h7FFF_FFFF, 9'd256, 16'h7FFF, 1);
`else
    frame("overflow", 32'h7FFF_FFFF, 9'd256, 16'hFFFF, 0);
`endif
    frame("mute", 32'h0765_4321, 9'd0, 16'h0000, 0);

    for (int i = 0; i < 6; i++) begin
      s = $urandom;
      s = $signed(s) >>> $urandom_range(0, 28);
      v = 9'($urandom_range(0, 511));
      w = ref_word(s, int'(v), c);
      frame($sformatf("rand%0d", i), s, v, w, c);
    end

    a = 32'h0012_3400;
    b = 32'hFFAB_CD00;
    sample_in = a;
    master_vol = 9'd256;
    collect("midchange", 64, 20, b);
    check("midchange old frame", got_bits, frame_bits(ref_word(a, 256, c)));
    collect("midchange next", 64, -1, 32'd0);
    check("midchange new frame", got_bits, frame_bits(ref_word(b, 256, c)));

    collect("rst_mid", 41, -1, 32'd0);
    check("rst_mid lrclk before", 64'(lrclk), 64'd1);
    rst = 1'b1;
    tick();
    check("rst_mid outputs", 64'({bclk, lrclk, sdata, frame_start, clipped}), 64'd0);
    startup("restart");
    frame("after restart", 32'h0012_3400, 9'd256, 16'h1234, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sublime_i2s_out.md
SUBLIME_I2S_OUT -- requirements
Module: sublime_i2s_out

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per BCLK half-period; legal range 4..255.
REQ-002 SHALL have parameter SAMPLE_BITS, default 16: output word width; legal values 16 or 24.
REQ-003 SHALL have parameter HEADROOM_SHIFT, default 8: arithmetic right shift applied after volume scaling; legal range 0..16.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 sample_in  in  32  signed mixed sample, held by the upstream mixer between updates.
REQ-007 master_vol  in  9  unsigned gain; 256 = unity, 0 = mute.
REQ-008 frame_start  out  1  one-clk pulse when sample_in is captured.
REQ-009 clipped  out  1  one-clk pulse when the captured sample saturated.
REQ-010 bclk  out  1  I2S bit clock.
REQ-011 lrclk  out  1  I2S word select; 0 = left, 1 = right.
REQ-012 sdata  out  1  I2S serial data.

Function
REQ-013 Divider SHALL count 0..CLK_DIV-1 and toggle bclk on wrap; bclk rises first CLK_DIV clks after rst release.
REQ-014 6-bit bitcnt SHALL advance on each bclk falling edge, wrapping 63->0; lrclk = bitcnt[5], updated on the same falling edge.
REQ-015 On the falling edge where bitcnt becomes 0, SHALL capture sample_in and master_vol and pulse frame_start for 1 clk.
REQ-016 Scaling stage 1 (1 clk): sign-magnitude multiply |sample| x master_vol -> 41-bit magnitude; sign = sample[31].
REQ-017 Scaling stage 2 (1 clk): scaled = signed product[40:8] (truncation toward zero), arithmetic shift right HEADROOM_SHIFT, reduce to SAMPLE_BITS per REQ-024/025; result valid 2 clks after capture.
REQ-018 Shift register (32 bits) SHALL load {word, zeros} on falling edges where bitcnt becomes 1 (left) and 33 (right); same word both channels.
REQ-019 Shift register SHALL otherwise shift left with 0 fill on each falling edge; sdata = shift register bit 31.
REQ-020 Therefore MSB appears one BCLK after each lrclk transition (standard I2S); bit slots after the LSB carry 0.
REQ-021 sample_in/master_vol changes between captures SHALL NOT affect the frame in progress.
REQ-022 clipped SHALL pulse for 1 clk when the stage-2 result is produced and saturation occurred.

Reset
REQ-023 rst SHALL force, next clk: bclk=0, lrclk=0, sdata=0, frame_start=0, clipped=0, divider=0, bitcnt=63, shift register=0, pipeline=0; assertion mid-frame aborts the frame, and the first capture follows the first falling edge after release.

Configuration
REQ-024 With SUBLIME_I2S_SATURATE_EN defined: values above 2^(SAMPLE_BITS-1)-1 or below -2^(SAMPLE_BITS-1) SHALL clamp to those limits and raise clipped.
REQ-025 Without SUBLIME_I2S_SATURATE_EN: low SAMPLE_BITS bits SHALL be taken (wrap), and clipped SHALL be tied 0.

Structure
REQ-026 sublime_pkg SHALL hold I2S_SLOT_BITS=32, I2S_FRAME_BITS=64, VOL_UNITY=256.
REQ-027 The two-stage sign-magnitude multiplier SHALL be a sub-module sublime_vol_scale, reusable by the voice mixer.

Verification (CLK_DIV=4, SAMPLE_BITS=16, HEADROOM_SHIFT=8)
REQ-028 rst held then released -> all outputs 0; first bclk rise 4 clks after release; bclk period 8 clks; lrclk period 512 clks.
REQ-029 sample_in=32'h0012_3400, master_vol=256 -> left and right slots serialize 16'h1234 MSB-first from bit slot 1, then 16 zero bits.
REQ-030 sample_in=32'hFFFF_EC00, master_vol=128 -> word 16'hFFF6, clipped=0.
REQ-031 sample_in=32'h7FFF_FFFF, master_vol=256 -> SATURATE_EN: 16'h7FFF with one clipped pulse per frame; without: 16'hFFFF, clipped never asserts.
REQ-032 sample_in changed at bitcnt 20 -> current frame unchanged; new value serialized only after the next frame_start.
REQ-033 rst asserted at bitcnt 40 -> all outputs 0 next clk; sequence restarts per REQ-028 after release.
